pcie_reset_seq: RTL and testbench

PCIE_RESET_SEQ -- requirements
Module: pcie_reset_seq

---
 rtl/pcie_reset_seq.sv | 142 ++++++++++++++
 tb/tb_pcie_reset_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_reset_seq.sv
// PCIe bring-up reset sequencer: synchronizes board status, filters PLL lock, and releases
// fabric/core/application resets in order, with lock-loss, link-loss and software restart paths.
module pcie_reset_seq #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned LOCK_FILTER  = 16,
  parameter int unsigned RESET_HOLD   = 64,
  parameter int unsigned LINK_TIMEOUT = 1000000
) (
  input  logic       clk_i,
  input  logic       fabric_por_ni,
  input  logic       device_init_done_i,
  input  logic       bank0_1_4_calib_done_i,
  input  logic       pll_lock_i,
  input  logic       link_up_i,
  input  logic       sw_reset_req_i,
  output logic       fabric_reset_no,
  output logic       pcie_core_reset_no,
  output logic       app_reset_no,
  output logic       init_done_o,
  output logic       init_fail_o,
  output logic [2:0] state_o
);

  localparam int unsigned LockW = (LOCK_FILTER > 2) ? $clog2(LOCK_FILTER) : 1;
  localparam int unsigned HoldW = $clog2(RESET_HOLD + 1);
  localparam int unsigned LinkW = 24;

  typedef enum logic [2:0] {
    StWaitInit = 3'd0,
    StWaitLock = 3'd1,
    StHold     = 3'd2,
    StCoreRel  = 3'd3,
    StWaitLink = 3'd4,
    StRun      = 3'd5,
    StFail     = 3'd6
  } state_e;

  state_e                       state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0]  sync_q;
  logic [LockW-1:0]             lock_cnt_q, lock_cnt_d;
  logic [HoldW-1:0]             hold_cnt_q, hold_cnt_d;
  logic [LinkW-1:0]             link_cnt_q, link_cnt_d;
  logic                         core_rel_q, core_rel_d;
  logic                         app_rel_q, app_rel_d;

  logic init_s, calib_s, lock_s, link_s;
  logic sw_take, status_lost, lock_lost;

  // Bit order in each stage: {link, lock, calib, init}.
  assign init_s  = sync_q[SYNC_STAGES-1][0];
  assign calib_s = sync_q[SYNC_STAGES-1][1];
  assign lock_s  = sync_q[SYNC_STAGES-1][2];
  assign link_s  = sync_q[SYNC_STAGES-1][3];

  assign status_lost = (state_q != StWaitInit) && !(init_s && calib_s);
  assign lock_lost   = !lock_s && (state_q inside {StHold, StCoreRel, StWaitLink, StRun});
  assign sw_take     = sw_reset_req_i && (state_q != StWaitInit);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    hold_cnt_d = '0;
    link_cnt_d = '0;

    // Lock filter only moves in WAIT_LOCK and is otherwise retained, except in WAIT_INIT.
    if (state_q == StWaitInit) begin
      lock_cnt_d = '0;
    end else if (state_q == StWaitLock) begin
      if (!lock_s) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q != LockW'(LOCK_FILTER - 1)) begin
        lock_cnt_d = lock_cnt_q + LockW'(1);
      end
    end

    if (state_q == StHold && !sw_take) begin
      hold_cnt_d = (hold_cnt_q == HoldW'(RESET_HOLD)) ? hold_cnt_q : hold_cnt_q + HoldW'(1);
    end

    if (state_q == StWaitLink) begin
      link_cnt_d = (link_cnt_q == LinkW'(LINK_TIMEOUT - 1)) ? link_cnt_q
                                                            : link_cnt_q + LinkW'(1);
    end

    if (status_lost) begin
      state_d = StWaitInit;
    end else if (lock_lost) begin
      state_d = StWaitLock;
    end else if (sw_take) begin
      state_d = StHold;
    end else begin
      unique case (state_q)
        StWaitInit: if (init_s && calib_s) state_d = StWaitLock;
        StWaitLock: if (lock_s && lock_cnt_q == LockW'(LOCK_FILTER - 1)) state_d = StHold;
        StHold:     if (hold_cnt_q == HoldW'(RESET_HOLD)) state_d = StCoreRel;
        StCoreRel:  state_d = StWaitLink;
        StWaitLink: begin
          if (link_s) begin
            state_d = StRun;
          end else if (link_cnt_q == LinkW'(LINK_TIMEOUT - 1)) begin
            state_d = StFail;
          end
        end
        StRun:      if (!link_s) state_d = StWaitLink;
        StFail:     state_d = StFail;
        default:    state_d = StWaitInit;
      endcase
    end

    core_rel_d = state_d inside {StCoreRel, StWaitLink, StRun};
    app_rel_d  = (state_d == StRun);
  end

  always_ff @(posedge clk_i or negedge fabric_por_ni) begin
    if (!fabric_por_ni) begin
      state_q    <= StWaitInit;
      sync_q     <= '0;
      lock_cnt_q <= '0;
      hold_cnt_q <= '0;
      link_cnt_q <= '0;
      core_rel_q <= 1'b0;
      app_rel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0],
                     {link_up_i, pll_lock_i, bank0_1_4_calib_done_i, device_init_done_i}};
      lock_cnt_q <= lock_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      link_cnt_q <= link_cnt_d;
      core_rel_q <= core_rel_d;
      app_rel_q  <= app_rel_d;
    end
  end

  assign fabric_reset_no    = core_rel_q;
  assign pcie_core_reset_no = core_rel_q;
  assign app_reset_no       = app_rel_q;
  assign init_done_o        = (state_q == StRun);
  assign init_fail_o        = (state_q == StFail);
  assign state_o            = state_q;

endmodule

// File: tb/tb_pcie_reset_seq.sv
// Directed bench for pcie_reset_seq: each scenario checks the packed output bundle
// {state, fabric_n, core_n, app_n, done, fail} at hand-computed cycles after reset release.
module tb_pcie_reset_seq;

  logic       clk_i = 1'b0;
  logic       fabric_por_ni;
  logic       device_init_done_i, bank0_1_4_calib_done_i, pll_lock_i, link_up_i;
  logic       sw_reset_req_i;
  logic       fabric_reset_no, pcie_core_reset_no, app_reset_no, init_done_o, init_fail_o;
  logic [2:0] state_o;
  logic [7:0] obs;
  logic [7:0] exp_v;
  logic       chk;

  int vec = 0;
  int err = 0;

  localparam logic [7:0] EWI = 8'b000_00000;
  localparam logic [7:0] EWL = 8'b001_00000;
  localparam logic [7:0] EHO = 8'b010_00000;
  localparam logic [7:0] ECR = 8'b011_11000;
  localparam logic [7:0] EWK = 8'b100_11000;
  localparam logic [7:0] ERN = 8'b101_11110;
  localparam logic [7:0] EFL = 8'b110_00001;

  always #5 clk_i = ~clk_i;

  assign obs = {state_o, fabric_reset_no, pcie_core_reset_no, app_reset_no, init_done_o,
                init_fail_o};

  pcie_reset_seq #(
    .SYNC_STAGES (2),
    .LOCK_FILTER (4),
    .RESET_HOLD  (8),
    .LINK_TIMEOUT(100)
  ) dut (
    .clk_i                 (clk_i),
    .fabric_por_ni         (fabric_por_ni),
    .device_init_done_i    (device_init_done_i),
    .bank0_1_4_calib_done_i(bank0_1_4_calib_done_i),
    .pll_lock_i            (pll_lock_i),
    .link_up_i             (link_up_i),
    .sw_reset_req_i        (sw_reset_req_i),
    .fabric_reset_no       (fabric_reset_no),
    .pcie_core_reset_no    (pcie_core_reset_no),
    .app_reset_no          (app_reset_no),
    .init_done_o           (init_done_o),
    .init_fail_o           (init_fail_o),
    .state_o               (state_o)
  );

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  // Hold reset with the given input levels, then release on a falling edge so that the
  // next rising edge is cycle 1.
  task automatic start_seq(input logic lk, input logic lu);
    fabric_por_ni          = 1'b0;
    device_init_done_i     = 1'b1;
    bank0_1_4_calib_done_i = 1'b1;
    pll_lock_i             = lk;
    link_up_i              = lu;
    sw_reset_req_i         = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    fabric_por_ni = 1'b1;
  endtask

  task automatic test_reset;
    fabric_por_ni          = 1'b0;
    device_init_done_i     = 1'b1;
    bank0_1_4_calib_done_i = 1'b1;
    pll_lock_i             = 1'b1;
    link_up_i              = 1'b1;
    sw_reset_req_i         = 1'b1;
    #3;
    vec++;
    if (obs !== EWI) begin
      $display("FAIL reset_immediate: got %b want %b", obs, EWI);
      err++;
    end
    for (int c = 1; c <= 5; c++) step();
    vec++;
    if (obs !== EWI) begin
      $display("FAIL reset_held: got %b want %b", obs, EWI);
      err++;
    end
    sw_reset_req_i = 1'b0;
  endtask

  task automatic test_nominal;
    start_seq(1'b1, 1'b0);
    for (int c = 1; c <= 34; c++) begin
      step();
      chk = 1'b1;
      case (c)
        2:       exp_v = EWI;
        3:       exp_v = EWL;
        6:       exp_v = EWL;
        7:       exp_v = EHO;
        15:      exp_v = EHO;
        16:      exp_v = ECR;
        17:      exp_v = EWK;
        32:      exp_v = EWK;
        33:      exp_v = ERN;
        default: chk = 1'b0;
      endcase
      if (chk) begin
        vec++;
        if (obs !== exp_v) begin
          $display("FAIL nominal c%0d: got %b want %b", c, obs, exp_v);
          err++;
        end
      end
      if (c == 30) link_up_i = 1'b1;
    end
  endtask

  task automatic test_lock_glitch;
    start_seq(1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      step();
      chk = 1'b1;
      case (c)
        3:       exp_v = EWL;
        7:       exp_v = EWL;
        9:       exp_v = EWL;
        10:      exp_v = EHO;
        default: chk = 1'b0;
      endcase
      if (chk) begin
        vec++;
        if (obs !== exp_v) begin
          $display("FAIL lock_glitch c%0d: got %b want %b", c, obs, exp_v);
          err++;
        end
      end
      if (c == 3) pll_lock_i = 1'b0;
      if (c == 4) pll_lock_i = 1'b1;
    end
  endtask

  task automatic test_timeout;
    start_seq(1'b1, 1'b0);
    for (int c = 1; c <= 131; c++) begin
      step();
      chk = 1'b1;
      case (c)
        17:      exp_v = EWK;
        116:     exp_v = EWK;
        117:     exp_v = EFL;
        120:     exp_v = EFL;
        121:     exp_v = EHO;
        129:     exp_v = EHO;
        130:     exp_v = ECR;
        default: chk = 1'b0;
      endcase
      if (chk) begin
        vec++;
        if (obs !== exp_v) begin
          $display("FAIL timeout c%0d: got %b want %b", c, obs, exp_v);
          err++;
        end
      end
      if (c == 120) sw_reset_req_i = 1'b1;
      if (c == 121) sw_reset_req_i = 1'b0;
    end
  endtask

  task automatic test_lock_loss;
    start_seq(1'b1, 1'b1);
    for (int c = 1; c <= 42; c++) begin
      step();
      chk = 1'b1;
      case (c)
        18:      exp_v = ERN;
        22:      exp_v = ERN;
        23:      exp_v = EWL;
        30:      exp_v = EWL;
        31:      exp_v = EHO;
        40:      exp_v = ECR;
        42:      exp_v = ERN;
        default: chk = 1'b0;
      endcase
      if (chk) begin
        vec++;
        if (obs !== exp_v) begin
          $display("FAIL lock_loss c%0d: got %b want %b", c, obs, exp_v);
          err++;
        end
      end
      if (c == 20) pll_lock_i = 1'b0;
      if (c == 25) pll_lock_i = 1'b1;
    end
  endtask

  task automatic test_async_reset;
    start_seq(1'b1, 1'b0);
    for (int c = 1; c <= 20; c++) step();
    vec++;
    if (obs !== EWK) begin
      $display("FAIL async_pre: got %b want %b", obs, EWK);
      err++;
    end
    #2;
    fabric_por_ni = 1'b0;
    #1;
    vec++;
    if (obs !== EWI) begin
      $display("FAIL async_now: got %b want %b", obs, EWI);
      err++;
    end
    for (int c = 1; c <= 3; c++) step();
    vec++;
    if (obs !== EWI) begin
      $display("FAIL async_held: got %b want %b", obs, EWI);
      err++;
    end
    @(negedge clk_i);
    fabric_por_ni = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      step();
      chk = 1'b1;
      case (c)
        2:       exp_v = EWI;
        3:       exp_v = EWL;
        7:       exp_v = EHO;
        16:      exp_v = ECR;
        17:      exp_v = EWK;
        default: chk = 1'b0;
      endcase
      if (chk) begin
        vec++;
        if (obs !== exp_v) begin
          $display("FAIL async_restart c%0d: got %b want %b", c, obs, exp_v);
          err++;
        end
      end
    end
  endtask

  task automatic test_simultaneous;
    start_seq(1'b1, 1'b1);
    for (int c = 1; c <= 28; c++) begin
      step();
      chk = 1'b1;
      case (c)
        18:      exp_v = ERN;
        22:      exp_v = ERN;
        23:      exp_v = EWI;
        25:      exp_v = EWI;
        28:      exp_v = EWI;
        default: chk = 1'b0;
      endcase
      if (chk) begin
        vec++;
        if (obs !== exp_v) begin
          $display("FAIL simultaneous c%0d: got %b want %b", c, obs, exp_v);
          err++;
        end
      end
      if (c == 20) begin
        bank0_1_4_calib_done_i = 1'b0;
        pll_lock_i             = 1'b0;
      end
      if (c == 22 || c == 24) sw_reset_req_i = 1'b1;
      if (c == 23 || c == 25) sw_reset_req_i = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_glitch();
    test_timeout();
    test_lock_loss();
    test_async_reset();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
